uart_rx_framer: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 33 +++
 rtl/uart_rx_framer.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_framer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive framer
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d_in,
  output logic q_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: a plain two-stage shift of the raw input.
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  // Synchronizer flops; reset to the line's idle level so no false edge is seen.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - 8N1 UART receiver with false-start rejection and framing errors (optional even parity: UART_RX_PARITY_EN)
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 17
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       framing_err_out,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_out,
`endif
  output logic       busy_out
);

  // Start-edge to start-bit mid-sample delay; derived only.
  localparam int HALF_BAUD = CLOCKS_PER_BAUD / 2;
  localparam int CW        = $clog2(CLOCKS_PER_BAUD) + 1;

  logic rx_s;

  rx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif
  logic              sample;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d_in     (rx_in),
    .q_out    (rx_s)
  );

  assign sample = (cnt_q == '0);

  // Frame FSM: baud timing, bit capture and one-cycle result strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    // The counter only runs while a frame is being timed.
    if (state_q != IDLE && state_q != BREAK) begin
      cnt_d = sample ? CW'(CLOCKS_PER_BAUD - 1) : cnt_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CW'(HALF_BAUD - 1);
        end
      end
      START: begin
        if (sample) begin
          if (rx_s) begin
            state_d = IDLE;               // glitch, not a real start bit
          end else begin
            state_d = DATA;
            bit_d   = 3'd0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          par_d   = (^shift_q) ^ rx_s;   // 1 means even parity violated
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (rx_s) begin
            valid_d = 1'b1;
            data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_q;
`endif
            state_d = IDLE;               // back at mid-stop, ready for a back-to-back start
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out        = data_q;
  assign valid_out       = valid_q;
  assign framing_err_out = ferr_q;
  assign busy_out        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_out  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - randomized self-checking bench for uart_rx_framer against an event-level reference model
module tb_uart_rx_framer;

  localparam int CPB  = 17;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // Pin-to-strobe: synchronizer + half bit + remaining bit periods up to stop middle + output register.
  localparam int LAT = 2 + HALF + NBITS * CPB + 1;

  typedef struct {
    int cyc;
    int kind;   // bit0 valid, bit1 framing error, bit2 parity error
    int data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       framing_err_out;
  logic       busy_out;
  logic       perr_w;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_out;
  assign perr_w = parity_err_out;
`else
  assign perr_w = 1'b0;
`endif

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  last_good = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t mon_e;

  uart_rx_framer #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .rx_in           (rx),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .framing_err_out (framing_err_out),
`ifdef UART_RX_PARITY_EN
    .parity_err_out  (parity_err_out),
`endif
    .busy_out        (busy_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe the DUT produces, stamped with its cycle.
  always @(negedge clk) begin
    if (rst_n && (valid_out || framing_err_out || perr_w)) begin
      mon_e.cyc  = cyc;
      mon_e.kind = int'({perr_w, framing_err_out, valid_out});
      mon_e.data = int'(data_out);
      obs_q.push_back(mon_e);
    end
  end

  task automatic check(input string tag, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  task automatic bit_time(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame and records what the receiver must report for it.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pbit, output int fall);
    ev_t e;
    fall   = cyc;
    e.cyc  = cyc + LAT;
    if (stop_bit) begin
      e.kind = 1;
`ifdef UART_RX_PARITY_EN
      if ((^b) ^ pbit) e.kind = 5;
`endif
      e.data    = int'(b);
      last_good = int'(b);
    end else begin
      e.kind = 2;
      e.data = last_good;
    end
    exp_q.push_back(e);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(pbit);
`else
    if (pbit) rx = 1'b1;
`endif
    bit_time(stop_bit);
    rx = 1'b1;
  endtask

  task automatic compare_events(input string tag);
    int n;
    check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_%0d_cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s_%0d_kind", tag, i), obs_q[i].kind, exp_q[i].kind);
      check($sformatf("%s_%0d_data", tag, i), obs_q[i].data, exp_q[i].data);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int fall;
    int fall_w;
    int busy_cnt;
    logic [7:0] seq [9];
    logic [7:0] b;
    logic sb;
    logic pb;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", int'(data_out), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_ferr", int'(framing_err_out), 0);
    check("rst_busy", int'(busy_out), 0);
    rst_n = 1'b1;
    idle(5);

    // Single 'W'.
    send_frame(8'h57, 1'b1, ^8'h57, fall_w);
    idle(40);
    check("w_latency", (obs_q.size() > 0) ? obs_q[0].cyc - fall_w : -1, LAT);
    compare_events("w");

    // Back-to-back frames, one stop bit each.
    seq = '{8'h57, 8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < 9; i++) send_frame(seq[i], 1'b1, ^seq[i], fall);
    idle(40);
    compare_events("b2b");

    // False start: short low glitch.
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) rx = 1'b1;
      @(negedge clk);
      if (busy_out) busy_cnt++;
      @(posedge clk);
      #1;
    end
    check("false_start_busy", busy_cnt, HALF);
    compare_events("false_start");

    // Framing error followed by a held break, then recovery.
    send_frame(8'hA5, 1'b0, ^8'hA5, fall);
    rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("break_busy", int'(busy_out), 1);
    idle(5);
    check("break_exit_busy", int'(busy_out), 0);
    send_frame(8'h3C, 1'b1, ^8'h3C, fall);
    idle(40);
    compare_events("ferr");

    // Reset during data bit 4 of 0xFF.
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    rx = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_data", int'(data_out), 0);
    check("midrst_busy", int'(busy_out), 0);
    check("midrst_valid", int'(valid_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_good = 0;
    idle(10 * CPB);
    send_frame(8'h12, 1'b1, ^8'h12, fall);
    idle(40);
    compare_events("midrst");

`ifdef UART_RX_PARITY_EN
    // Parity: good then bad parity bit on 0x07.
    send_frame(8'h07, 1'b1, 1'b1, fall);
    idle(3);
    send_frame(8'h07, 1'b1, 1'b0, fall);
    idle(40);
    compare_events("parity");
`endif

    // Randomized frames, gaps, stop errors and parity flips.
    for (int i = 0; i < 16; i++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 4) != 0);
      pb = (^b) ^ ($urandom_range(0, 3) == 0);
      send_frame(b, sb, pb, fall);
      idle(sb ? $urandom_range(0, 20) : $urandom_range(5, 20));
    end
    idle(40);
    compare_events("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
